// File: rtl/fpu_pkg.sv
// Shared FPU adder-path types: exponent/mantissa widths, normalizer FSM states, result bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 26;
    localparam int MANT_W = 23;

    localparam logic [EXP_W-1:0] MAX_EXP      = 8'hFF;
    localparam logic [EXP_W-1:0] OVF_EDGE_EXP = MAX_EXP - 8'd1;
    localparam logic [EXP_W-1:0] EXP_ONE      = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
        logic              guard;
        logic              sticky;
        logic              ovf;
        logic              unf;
    } norm_result_t;

endpackage

// File: rtl/fp_norm_step.sv
// Single normalization step: picks the one highest-priority action for the current frac/exp.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module fp_norm_step
    import fpu_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    input  logic [EXP_W-1:0]  exp,
    input  logic              sticky,
    output logic [FRAC_W-1:0] nxt_frac,
    output logic [EXP_W-1:0]  nxt_exp,
    output logic              nxt_sticky,
    output logic              ovf,
    output logic              unf,
    output logic              done
);

    always_comb begin
        nxt_frac   = frac;
        nxt_exp    = exp;
        nxt_sticky = sticky;
        ovf        = 1'b0;
        unf        = 1'b0;
        done       = 1'b1;

        if (exp == MAX_EXP) begin
            // inf/NaN operands pass through untouched
        end else if (frac == '0) begin
            nxt_exp = '0;
            unf     = 1'b1;
        end else if (frac[FRAC_W-1]) begin
            if (exp == OVF_EDGE_EXP) begin
                nxt_exp  = MAX_EXP;
                nxt_frac = '0;
                ovf      = 1'b1;
            end else begin
                nxt_frac   = {1'b0, frac[FRAC_W-1:1]};
                nxt_sticky = sticky | frac[0];
                nxt_exp    = exp + 8'd1;
            end
        end else if (frac[FRAC_W-2]) begin
            // hidden one already in place
        end else if (exp <= EXP_ONE) begin
            // exponent floor reached: leave the magnitude as a denormal
            nxt_exp = '0;
            unf     = 1'b1;
        end else begin
            nxt_frac = {frac[FRAC_W-2:0], 1'b0};
            nxt_exp  = exp - 8'd1;
            done     = 1'b0;
        end
    end

endmodule

// File: rtl/fp_normalize_seq.sv
// Iterative post-add normalizer: one bit of shift per cycle, guard/sticky kept for the rounder.
// Latency: 2 cycles from accept when no left shift is needed, 2+k for k left shifts (max 26).
// Backpressure: valid/ready both sides; result held while out_ready is low, no accept until drained.
module fp_normalize_seq
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_frac,
    output logic              out_guard,
    output logic              out_sticky,
    output logic              out_ovf,
    output logic              out_unf
);

    norm_state_t       state;
    norm_state_t       state_nxt;
    logic              sign_q;
    logic [FRAC_W-1:0] frac_q;
    logic [EXP_W-1:0]  exp_q;
    logic              sticky_q;
    logic              ovf_q;
    logic              unf_q;

    logic [FRAC_W-1:0] step_frac;
    logic [EXP_W-1:0]  step_exp;
    logic              step_sticky;
    logic              step_ovf;
    logic              step_unf;
    logic              step_done;

    norm_result_t      res;

    fp_norm_step u_step (
        .frac       (frac_q),
        .exp        (exp_q),
        .sticky     (sticky_q),
        .nxt_frac   (step_frac),
        .nxt_exp    (step_exp),
        .nxt_sticky (step_sticky),
        .ovf        (step_ovf),
        .unf        (step_unf),
        .done       (step_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (step_done) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Step results are only committed in SHIFT, so DONE holds the result stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            frac_q   <= '0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        frac_q   <= in_frac;
                        exp_q    <= in_exp;
                        sticky_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    frac_q   <= step_frac;
                    exp_q    <= step_exp;
                    sticky_q <= step_sticky;
                    ovf_q    <= step_ovf;
                    unf_q    <= step_unf;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        res.sign   = sign_q;
        res.exp    = exp_q;
        res.frac   = frac_q[MANT_W:1];
        res.guard  = frac_q[0];
        res.sticky = sticky_q;
        res.ovf    = ovf_q;
        res.unf    = unf_q;
    end

    assign out_sign   = res.sign;
    assign out_exp    = res.exp;
    assign out_frac   = res.frac;
    assign out_guard  = res.guard;
    assign out_sticky = res.sticky;
    assign out_ovf    = res.ovf;
    assign out_unf    = res.unf;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Scoreboarded bench for fp_normalize_seq: directed operands with hand-derived results and latencies.
module tb_fp_normalize_seq;

    typedef struct {
        logic        sign;
        logic [25:0] frac;
        logic [7:0]  exp;
        logic [7:0]  e_exp;
        logic [22:0] e_frac;
        logic        e_guard;
        logic        e_sticky;
        logic        e_ovf;
        logic        e_unf;
        int          e_lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [25:0] in_frac;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_guard;
    logic        out_sticky;
    logic        out_ovf;
    logic        out_unf;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cur_lat = -1;
    int   last_acc = -1;
    int   last_xfer = -1;
    logic prev_ov = 1'b0;

    vec_t exp_q[$];
    int   acc_q[$];
    vec_t vecs[12];

    fp_normalize_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_frac    (in_frac),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_frac   (out_frac),
        .out_guard  (out_guard),
        .out_sticky (out_sticky),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [25:0] f, input logic [7:0] e,
                                input logic [7:0] ee, input logic [22:0] ef, input logic eg,
                                input logic es, input logic eo, input logic eu, input int el);
        vec_t v;
        v.sign = s;  v.frac = f;  v.exp = e;
        v.e_exp = ee; v.e_frac = ef; v.e_guard = eg; v.e_sticky = es;
        v.e_ovf = eo; v.e_unf = eu; v.e_lat = el;
        return v;
    endfunction

    // Monitor: tracks accepts, first-valid latency, and scores every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc);
                last_acc = cyc;
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() > 0) cur_lat = cyc - acc_q.pop_front();
                else cur_lat = -1;
            end
            if (out_valid && out_ready) begin
                last_xfer = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: exp=0x%0h frac=0x%0h with nothing outstanding", out_exp, out_frac);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    chk("out_sign",   out_sign,   e.sign);
                    chk("out_exp",    out_exp,    e.e_exp);
                    chk("out_frac",   out_frac,   e.e_frac);
                    chk("out_guard",  out_guard,  e.e_guard);
                    chk("out_sticky", out_sticky, e.e_sticky);
                    chk("out_ovf",    out_ovf,    e.e_ovf);
                    chk("out_unf",    out_unf,    e.e_unf);
                    chk("latency",    cur_lat,    e.e_lat);
                end
            end
            prev_ov = out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input bit push, input bit hold);
        bit ok;
        ok       = 1'b0;
        in_sign  = v.sign;
        in_frac  = v.frac;
        in_exp   = v.exp;
        in_valid = 1'b1;
        if (push) exp_q.push_back(v);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b after 200 cycles, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        if (!hold || !ok) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1'b1, 26'h1000000, 8'd127, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        vecs[1]  = mk(1'b0, 26'h3000003, 8'd100, 8'd101, 23'h400000, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        vecs[2]  = mk(1'b0, 26'h0080000, 8'd130, 8'd125, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 7);
        vecs[3]  = mk(1'b1, 26'h0000100, 8'd3,   8'd0,   23'h000200, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        vecs[4]  = mk(1'b0, 26'h0000000, 8'd50,  8'd0,   23'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        vecs[5]  = mk(1'b0, 26'h2000000, 8'd254, 8'd255, 23'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        vecs[6]  = mk(1'b1, 26'h0000003, 8'd255, 8'd255, 23'h000001, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        vecs[7]  = mk(1'b0, 26'h2000001, 8'd253, 8'd254, 23'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        vecs[8]  = mk(1'b0, 26'h0000001, 8'd127, 8'd103, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 26);
        vecs[9]  = mk(1'b0, 26'h1000005, 8'd0,   8'd0,   23'h000002, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        vecs[10] = mk(1'b1, 26'h0C00001, 8'd10,  8'd9,   23'h400001, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        vecs[11] = mk(1'b0, 26'h0400000, 8'd1,   8'd0,   23'h200000, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_frac   = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_exp",   out_exp,   0);
        chk("rst_out_frac",  out_frac,  0);
        chk("rst_out_flags", {out_sign, out_guard, out_sticky, out_ovf, out_unf}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i], 1'b1, 1'b0);
            wait_drain();
        end

        // Backpressure: result must hold for three cycles with out_ready low.
        out_ready = 1'b0;
        send(vecs[2], 1'b1, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("stall_valid_seen", seen, 1);
            for (int h = 0; h < 3; h++) begin
                if (h > 0) @(negedge clk);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready",  in_ready,  0);
                chk("stall_out_exp",   out_exp,   vecs[2].e_exp);
                chk("stall_out_frac",  out_frac,  vecs[2].e_frac);
                chk("stall_out_unf",   out_unf,   vecs[2].e_unf);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        wait_drain();

        // Reset in the middle of a long left-shift sequence: no result may emerge.
        send(vecs[8], 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_out_exp",   out_exp,   0);
        chk("midrst_out_frac",  out_frac,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 30; n++) @(posedge clk);
        #1;
        send(vecs[0], 1'b1, 1'b0);
        wait_drain();

        // Back-to-back with in_valid held: second accept lands one cycle after the first transfer.
        send(vecs[1], 1'b1, 1'b1);
        send(vecs[5], 1'b1, 1'b0);
        chk("b2b_accept_cycle", last_acc, last_xfer + 1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
